// File: rtl/modexp_pkg.sv
// Shared definitions for the modular-exponentiation accelerator:
// register map, status/control bit positions and exponent FSM states.
package modexp_pkg;

    localparam logic [3:0] ADDR_CTRL   = 4'd0;
    localparam logic [3:0] ADDR_STATUS = 4'd1;
    localparam logic [3:0] ADDR_BASE   = 4'd2;
    localparam logic [3:0] ADDR_EXP    = 4'd3;
    localparam logic [3:0] ADDR_MOD    = 4'd4;
    localparam logic [3:0] ADDR_RESULT = 4'd5;
    localparam logic [3:0] ADDR_CYCLES = 4'd6;

    localparam int CTRL_START = 0;
    localparam int CTRL_IE    = 1;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REDUCE,
        S_MUL,
        S_SQR,
        S_FIN
    } state_t;

endpackage

// File: rtl/modexp_accelerator_modmul.sv
// Serial interleaved modular multiplier: p = a*b mod m, MSB-first over a.
// One op = issue cycle, W bit cycles, then a one-cycle done pulse with p valid.
// m = 0 selects plain W-bit arithmetic (reduction modulo 2^W).
module modmul_serial #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] m,
    output logic [W-1:0] p,
    output logic         done
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  m_q, m_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d;
    logic          done_q, done_d;

    logic [W:0] dbl, dbl_r, sum, sum_r;
    logic       m_zero;

    // One bit step: double and reduce, then conditionally add b and reduce.
    always_comb begin
        acc_d  = acc_q;
        a_d    = a_q;
        b_d    = b_q;
        m_d    = m_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;

        m_zero = (m_q == '0);
        dbl    = {acc_q, 1'b0};
        if (m_zero)
            dbl_r = {1'b0, dbl[W-1:0]};
        else if (dbl >= {1'b0, m_q})
            dbl_r = dbl - {1'b0, m_q};
        else
            dbl_r = dbl;

        sum = dbl_r + (a_q[W-1] ? {1'b0, b_q} : '0);
        if (m_zero)
            sum_r = {1'b0, sum[W-1:0]};
        else if (sum >= {1'b0, m_q})
            sum_r = sum - {1'b0, m_q};
        else
            sum_r = sum;

        if (start) begin
            acc_d = '0;
            a_d   = a;
            b_d   = b;
            m_d   = m;
            cnt_d = CW'(W);
            run_d = 1'b1;
        end else if (run_q) begin
            acc_d = sum_r[W-1:0];
            a_d   = {a_q[W-2:0], 1'b0};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // State registers; reset clears the whole datapath.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            m_q    <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            a_q    <= a_d;
            b_q    <= b_d;
            m_q    <= m_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign p    = acc_q;
    assign done = done_q;

endmodule

// File: rtl/modexp_accelerator.sv
// Memory-mapped modular exponentiation engine (right-to-left square-and-multiply).
// Holds the bus decode, register file, exponent FSM and busy-cycle counter.
module modexp_accelerator
    import modexp_pkg::*;
#(
    parameter int W     = 32,
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  address,
    input  logic        read,
    output logic [31:0] readdata,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic        irq
);

    state_t state_q, state_d;
    logic   issued_q, issued_d;
    logic   ie_q, ie_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;
    logic   err_q, err_d;

    logic [W-1:0]     base_q, base_d;
    logic [W-1:0]     exp_q, exp_d;
    logic [W-1:0]     mod_q, mod_d;
    logic [W-1:0]     result_q, result_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;

    logic [W-1:0] b_q, b_d;
    logic [W-1:0] e_q, e_d;
    logic [W-1:0] m_q, m_d;
    logic [W-1:0] r_q, r_d;

    logic [31:0] rdata_q, rdata_d;

    logic         mul_start, mul_done;
    logic [W-1:0] mul_a, mul_b, mul_p;
    logic         start_req;
    logic [31:0]  status_v, ctrl_v;

    modmul_serial #(.W(W)) u_mul (
        .clk   (clk),
        .reset (reset),
        .start (mul_start),
        .a     (mul_a),
        .b     (mul_b),
        .m     (m_q),
        .p     (mul_p),
        .done  (mul_done)
    );

    // Bus writes, cycle counter, exponent FSM and registered read mux.
    always_comb begin
        state_d   = state_q;
        issued_d  = issued_q;
        ie_d      = ie_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        base_d    = base_q;
        exp_d     = exp_q;
        mod_d     = mod_q;
        result_d  = result_q;
        cycles_d  = cycles_q;
        b_d       = b_q;
        e_d       = e_q;
        m_d       = m_q;
        r_d       = r_q;
        rdata_d   = rdata_q;
        mul_start = 1'b0;
        mul_a     = r_q;
        mul_b     = b_q;
        start_req = 1'b0;

        // Operand and start writes are refused while a run is in flight.
        if (write) begin
            case (address)
                ADDR_CTRL: begin
                    ie_d = writedata[CTRL_IE];
                    if (writedata[CTRL_START]) begin
                        if (busy_q) err_d = 1'b1;
                        else        start_req = 1'b1;
                    end
                end
                ADDR_STATUS: begin
                    if (writedata[ST_DONE]) done_d = 1'b0;
                    if (writedata[ST_ERR])  err_d  = 1'b0;
                end
                ADDR_BASE: if (busy_q) err_d = 1'b1; else base_d = writedata[W-1:0];
                ADDR_EXP:  if (busy_q) err_d = 1'b1; else exp_d  = writedata[W-1:0];
                ADDR_MOD:  if (busy_q) err_d = 1'b1; else mod_d  = writedata[W-1:0];
                default: ;
            endcase
        end

        if (busy_q && (cycles_q != {CNT_W{1'b1}}))
            cycles_d = cycles_q + CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    b_d      = base_q;
                    e_d      = exp_q;
                    m_d      = mod_q;
                    r_d      = (mod_q == W'(1)) ? '0 : W'(1);
                    done_d   = 1'b0;
                    cycles_d = '0;
                    busy_d   = 1'b1;
                    issued_d = 1'b0;
                    state_d  = (exp_q == '0) ? S_FIN : S_REDUCE;
                end
            end
            S_REDUCE: begin
                mul_a = b_q;
                mul_b = W'(1);
                if (!issued_q) begin
                    mul_start = 1'b1;
                    issued_d  = 1'b1;
                end else if (mul_done) begin
                    issued_d = 1'b0;
                    b_d      = mul_p;
                    state_d  = e_q[0] ? S_MUL : S_SQR;
                end
            end
            S_MUL: begin
                mul_a = r_q;
                mul_b = b_q;
                if (!issued_q) begin
                    mul_start = 1'b1;
                    issued_d  = 1'b1;
                end else if (mul_done) begin
                    issued_d = 1'b0;
                    r_d      = mul_p;
                    state_d  = (e_q[W-1:1] != '0) ? S_SQR : S_FIN;
                end
            end
            S_SQR: begin
                mul_a = b_q;
                mul_b = b_q;
                if (!issued_q) begin
                    mul_start = 1'b1;
                    issued_d  = 1'b1;
                end else if (mul_done) begin
                    issued_d = 1'b0;
                    b_d      = mul_p;
                    e_d      = e_q >> 1;
                    state_d  = e_q[1] ? S_MUL : S_SQR;
                end
            end
            S_FIN: begin
                result_d = r_q;
                busy_d   = 1'b0;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        status_v          = '0;
        status_v[ST_BUSY] = busy_q;
        status_v[ST_DONE] = done_q;
        status_v[ST_ERR]  = err_q;
        ctrl_v            = '0;
        ctrl_v[CTRL_IE]   = ie_q;

        // Reads sample the pre-write register values.
        if (read) begin
            case (address)
                ADDR_CTRL:   rdata_d = ctrl_v;
                ADDR_STATUS: rdata_d = status_v;
                ADDR_BASE:   rdata_d = 32'(base_q);
                ADDR_EXP:    rdata_d = 32'(exp_q);
                ADDR_MOD:    rdata_d = 32'(mod_q);
                ADDR_RESULT: rdata_d = 32'(result_q);
                ADDR_CYCLES: rdata_d = 32'(cycles_q);
                default:     rdata_d = '0;
            endcase
        end
    end

    // All state registers; reset aborts any run and clears everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            issued_q <= 1'b0;
            ie_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            base_q   <= '0;
            exp_q    <= '0;
            mod_q    <= '0;
            result_q <= '0;
            cycles_q <= '0;
            b_q      <= '0;
            e_q      <= '0;
            m_q      <= '0;
            r_q      <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            issued_q <= issued_d;
            ie_q     <= ie_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            base_q   <= base_d;
            exp_q    <= exp_d;
            mod_q    <= mod_d;
            result_q <= result_d;
            cycles_q <= cycles_d;
            b_q      <= b_d;
            e_q      <= e_d;
            m_q      <= m_d;
            r_q      <= r_d;
            rdata_q  <= rdata_d;
        end
    end

    assign readdata = rdata_q;
    assign irq      = done_q & ie_q;

endmodule

// File: tb/tb_modexp_accelerator.sv
// Directed bench for modexp_accelerator: table of exponentiation vectors plus
// hand-written sequences for reset, bus corner cases, errors, irq and abort.
module tb_modexp_accelerator;
    import modexp_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    int   total = 0;
    int   bad   = 0;
    logic ie_bit;

    typedef struct {
        logic [31:0] base;
        logic [31:0] exp;
        logic [31:0] mod;
        logic [31:0] res;
        int          busy;
    } vec_t;

    vec_t vecs[10];

    modexp_accelerator #(.W(32), .CNT_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .read      (read),
        .readdata  (readdata),
        .write     (write),
        .writedata (writedata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(negedge clk);
        write     = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        read    = 1'b1;
        @(negedge clk);
        read    = 1'b0;
        d       = readdata;
    endtask

    task automatic load(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m);
        wr(ADDR_BASE, b);
        wr(ADDR_EXP, e);
        wr(ADDR_MOD, m);
    endtask

    // Start a run and count cycles in which STATUS.BUSY reads 1.
    task automatic start_count(output int n);
        wr(ADDR_CTRL, {30'b0, ie_bit, 1'b1});
        address = ADDR_STATUS;
        read    = 1'b1;
        n       = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (readdata[0]) n++;
            else if (n > 0) break;
        end
        read = 1'b0;
    endtask

    task automatic wait_done();
        logic [31:0] s;
        bit          seen;
        seen = 0;
        for (int i = 0; i < 3000; i++) begin
            rd(ADDR_STATUS, s);
            if (s[1]) begin
                seen = 1;
                break;
            end
        end
        check("done_within_budget", {31'b0, seen}, 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        int          n;

        vecs[0] = '{32'd4,          32'd13,  32'd497,        32'd445,     239};
        vecs[1] = '{32'd3,          32'd5,   32'd0,          32'd243,     171};
        vecs[2] = '{32'd2,          32'd32,  32'd0,          32'd0,       239};
        vecs[3] = '{32'd0,          32'd0,   32'd0,          32'd1,       1};
        vecs[4] = '{32'd9,          32'd7,   32'd1,          32'd0,       205};
        vecs[5] = '{32'hFFFFFFFF,   32'd2,   32'hFFFFFFFB,   32'd16,      103};
        vecs[6] = '{32'd10,         32'd3,   32'd7,          32'd6,       137};
        vecs[7] = '{32'd5,          32'd117, 32'd19,         32'd1,       409};
        vecs[8] = '{32'd7,          32'd1,   32'd0,          32'd7,       69};
        vecs[9] = '{32'h00010001,   32'd3,   32'd0,          32'h00030001, 137};

        reset     = 1'b1;
        read      = 1'b0;
        write     = 1'b0;
        address   = '0;
        writedata = '0;
        ie_bit    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_readdata", readdata, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        reset = 1'b0;

        for (int a = 0; a < 8; a++) begin
            rd(4'(a), d);
            check($sformatf("rst_reg%0d", a), d, 32'd0);
        end

        // Unmapped addresses ignore writes and read zero.
        wr(4'd9, 32'hDEADBEEF);
        rd(4'd9, d);
        check("unmapped_9", d, 32'd0);
        wr(ADDR_RESULT, 32'h12345678);
        rd(ADDR_RESULT, d);
        check("result_read_only", d, 32'd0);

        // Simultaneous read and write: read returns the old value.
        wr(ADDR_BASE, 32'h11);
        @(negedge clk);
        address   = ADDR_BASE;
        writedata = 32'h55;
        write     = 1'b1;
        read      = 1'b1;
        @(negedge clk);
        write = 1'b0;
        read  = 1'b0;
        check("rw_same_cycle_old", readdata, 32'h11);
        rd(ADDR_BASE, d);
        check("rw_same_cycle_new", d, 32'h55);

        for (int i = 0; i < 10; i++) begin
            load(vecs[i].base, vecs[i].exp, vecs[i].mod);
            start_count(n);
            check($sformatf("v%0d_busy_cycles", i), 32'(n), 32'(vecs[i].busy));
            rd(ADDR_RESULT, d);
            check($sformatf("v%0d_result", i), d, vecs[i].res);
            rd(ADDR_CYCLES, d);
            check($sformatf("v%0d_cycles_reg", i), d, 32'(vecs[i].busy));
            rd(ADDR_STATUS, d);
            check($sformatf("v%0d_status", i), d, 32'h2);
        end

        // Interrupt enable with DONE already set raises irq; clearing drops it.
        ie_bit = 1'b1;
        wr(ADDR_CTRL, 32'h2);
        check("irq_on_ie_set", {31'b0, irq}, 32'd1);
        wr(ADDR_STATUS, 32'h6);
        check("irq_cleared", {31'b0, irq}, 32'd0);

        // Errors during a run: operand and START writes refused, run unchanged.
        load(32'd4, 32'd13, 32'd497);
        wr(ADDR_CTRL, 32'h3);
        repeat (20) @(negedge clk);
        check("irq_low_while_busy", {31'b0, irq}, 32'd0);
        rd(ADDR_RESULT, d);
        check("result_prev_while_busy", d, vecs[9].res);
        wr(ADDR_EXP, 32'd5);
        wr(ADDR_CTRL, 32'h3);
        rd(ADDR_STATUS, d);
        check("status_err_busy", d, 32'h5);
        wait_done();
        check("irq_at_done", {31'b0, irq}, 32'd1);
        rd(ADDR_RESULT, d);
        check("err_run_result", d, 32'd445);
        rd(ADDR_EXP, d);
        check("exp_unchanged", d, 32'd13);
        rd(ADDR_CYCLES, d);
        check("err_run_cycles", d, 32'd239);
        rd(ADDR_STATUS, d);
        check("status_done_err", d, 32'h6);
        wr(ADDR_STATUS, 32'h6);
        rd(ADDR_STATUS, d);
        check("status_w1c", d, 32'h0);
        check("irq_after_w1c", {31'b0, irq}, 32'd0);

        // Reset in the middle of a run aborts it.
        load(32'd4, 32'd13, 32'd497);
        wr(ADDR_CTRL, 32'h3);
        repeat (30) @(negedge clk);
        rd(ADDR_BASE, d);
        check("midrun_base_read", d, 32'd4);
        reset = 1'b1;
        #1;
        check("abort_readdata", readdata, 32'd0);
        check("abort_irq", {31'b0, irq}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rd(ADDR_STATUS, d);
        check("abort_status", d, 32'd0);
        rd(ADDR_RESULT, d);
        check("abort_result", d, 32'd0);
        rd(ADDR_CTRL, d);
        check("abort_ctrl", d, 32'd0);
        ie_bit = 1'b0;
        load(32'd4, 32'd13, 32'd497);
        start_count(n);
        check("rerun_busy_cycles", 32'(n), 32'd239);
        rd(ADDR_RESULT, d);
        check("rerun_result", d, 32'd445);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
